dpram_param: RTL and testbench
==============================

DPRAM_PARAM -- requirements
Module: dpram_param

Interface
REQ-001 Parameter: ADDRW, default 5, address width; depth DEPTH = 2^ADDRW words.
REQ-002 Parameter: DATAW, default 32, data width; SHALL be a multiple of 8; BYTES = DATAW/8.
REQ-003 Parameter: READ_REG, default 1; 0 = asynchronous read, 1 = registered read.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: raddr  input  ADDRW  read address.
REQ-007 Port: re  input  1  read enable; used only when READ_REG=1.
REQ-008 Port: dataout  output  DATAW  read data.
REQ-009 Port: waddr  input  ADDRW  write address.
REQ-010 Port: datain  input  DATAW  write data.
REQ-011 Port: be  input  BYTES  byte enables; bit i gates datain[8i+7:8i].
REQ-012 Port: we  input  1  write strobe.
REQ-013 Port: clear  input  1  single-cycle request to zero the whole array.
REQ-014 Port: busy  output  1  high while the clear sequencer owns the array.

Function
REQ-015 A write with we=1 and busy=0 SHALL update only the bytes whose be bit is 1 at memory[waddr] on the rising clock edge; a write with be=0 SHALL change nothing.
REQ-016 With READ_REG=0, dataout SHALL equal memory[raddr] combinationally, showing newly written data immediately after the write edge.
REQ-017 With READ_REG=1 and re=1, dataout SHALL register memory[raddr] with one-cycle latency; with re=0, dataout SHALL hold its previous value.
REQ-018 With READ_REG=1, re=1, we=1 and raddr==waddr in the same cycle, dataout SHALL be write-first per byte: enabled bytes from datain, disabled bytes from the old memory word.
REQ-019 The sequencer SHALL have two states, CLEAR and IDLE, and a clear counter of ADDRW bits.
REQ-020 In CLEAR, the sequencer SHALL write all-zero to memory[counter] each cycle and increment the counter; when the counter equals DEPTH-1, the next state SHALL be IDLE.
REQ-021 In IDLE, clear=1 SHALL set the next state to CLEAR with counter 0; clear=1 while in CLEAR SHALL restart the counter at 0.
REQ-022 busy SHALL be 1 exactly while in CLEAR, so one clear lasts exactly DEPTH cycles.
REQ-023 While busy=1, user writes SHALL be ignored (dropped, not queued).
REQ-024 While busy=1, dataout SHALL read as all-zero in both read modes.
REQ-025 Address wrap: the counter SHALL never exceed DEPTH-1; user addresses are always in range by width.

Reset
REQ-026 Asserting reset SHALL immediately force state CLEAR, counter 0, busy=1 and the registered dataout to 0, independent of clk.
REQ-027 After reset deasserts, the sequencer SHALL zero the array in DEPTH cycles before accepting writes.
REQ-028 Memory contents SHALL have no reset; an abandoned clear is restarted by the reset itself.

Structure
REQ-029 Package dpram_pkg SHALL hold the state encodings (ST_IDLE, ST_CLEAR) and the default parameter constants.
REQ-030 The clear sequencer (FSM, counter and busy) SHALL be the sub-module dpram_clrseq; the array, byte-enable write and read path SHALL live in dpram_param.
REQ-031 Configuration ADDRW=5, DATAW=8, READ_REG=0 SHALL behave as a plain 32x8 asynchronous-read dual-port RAM after the initial clear.

Verification
REQ-032 Reset release with ADDRW=5 -> busy=1 for exactly 32 cycles, then 0; reading all addresses afterwards returns 0x00000000.
REQ-033 Write 0xA1B2C3D4 with be=4'b1111 at address 3, then 0x55 with be=4'b0001 at address 3 -> a later read of address 3 returns 0xA1B2C355.
REQ-034 READ_REG=1, word 7 = 0x11223344, same-cycle write 0xFFFFFFFF with be=4'b1100 and read of address 7 -> next-cycle dataout is 0xFFFF3344.
REQ-035 Pulse clear at cycle 10 of a clear -> busy stays high 32 more cycles; a write issued during busy is absent afterwards.
REQ-036 Assert reset during a registered read holding 0xDEADBEEF -> dataout is 0 immediately with no clock edge, and busy=1.
REQ-037 READ_REG=0, write 0x5A to address 31 -> dataout on raddr=31 shows 0x5A in the same cycle after the edge; raddr=0 shows 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants and clear-sequencer state encoding for the dual-port RAM.
package dpram_pkg;

  localparam int unsigned DEF_ADDRW    = 5;
  localparam int unsigned DEF_DATAW    = 32;
  localparam int unsigned DEF_READ_REG = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dpram_clrseq.sv
// Clear sequencer: walks every address once, owning the array while busy.
module dpram_clrseq
  import dpram_pkg::*;
#(
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic             busy,
  output logic [ADDRW-1:0] addr
);

  localparam logic [ADDRW-1:0] LAST = '1;

  clr_state_e       state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;

  // State and counter register; reset starts a fresh clear pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a clear request always restarts from address 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDRW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    busy = (state_q == ST_CLEAR);
    addr = cnt_q;
  end

endmodule

// File: rtl/dpram_param.sv
// Parameterised dual-port RAM with byte enables, optional registered read
// and a self-clearing sequencer that zeroes the array after reset or clear.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int unsigned ADDRW    = DEF_ADDRW,
  parameter int unsigned DATAW    = DEF_DATAW,
  parameter int unsigned READ_REG = DEF_READ_REG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRW-1:0]   raddr,
  input  logic               re,
  output logic [DATAW-1:0]   dataout,
  input  logic [ADDRW-1:0]   waddr,
  input  logic [DATAW-1:0]   datain,
  input  logic [DATAW/8-1:0] be,
  input  logic               we,
  input  logic               clear,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << ADDRW;
  localparam int unsigned BYTES = DATAW / 8;

  logic [DATAW-1:0] mem [DEPTH];
  logic [ADDRW-1:0] clr_addr;
  logic             wr_en;

  dpram_clrseq #(
    .ADDRW (ADDRW)
  ) u_clrseq (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .addr  (clr_addr)
  );

  assign wr_en = we & ~busy;

  // Array write: the sequencer has priority, user writes are dropped while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= datain[8*i +: 8];
        end
      end
    end
  end

  if (READ_REG != 0) begin : g_reg
    logic [DATAW-1:0] rd_word;
    logic [DATAW-1:0] rd_q;

    // Write-first merge when reading the word being written this cycle.
    always_comb begin
      rd_word = mem[raddr];
      for (int i = 0; i < BYTES; i++) begin
        if (wr_en && be[i] && (raddr == waddr)) begin
          rd_word[8*i +: 8] = datain[8*i +: 8];
        end
      end
    end

    // Registered read; flushed to zero while the array is being cleared.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= '0;
      end else if (busy) begin
        rd_q <= '0;
      end else if (re) begin
        rd_q <= rd_word;
      end
    end

    assign dataout = busy ? '0 : rd_q;
  end else begin : g_async
    assign dataout = busy ? '0 : mem[raddr];
  end

endmodule

// File: tb/tb_dpram_param.sv
// Self-checking bench: registered-read 32x32 instance and async-read 32x8 instance.
module tb_dpram_param;

  logic        clk;
  logic        reset;

  logic [4:0]  r_raddr, r_waddr;
  logic        r_re, r_we, r_clear, r_busy;
  logic [31:0] r_din, r_dout;
  logic [3:0]  r_be;

  logic [4:0]  a_raddr, a_waddr;
  logic        a_re, a_we, a_clear, a_busy;
  logic [7:0]  a_din, a_dout;
  logic [0:0]  a_be;

  int n_checks;
  int n_fail;

  logic [31:0] model_r [32];
  logic [7:0]  model_a [32];
  logic [31:0] exp_rd;

  dpram_param #(.ADDRW(5), .DATAW(32), .READ_REG(1)) u_reg (
    .clk(clk), .reset(reset), .raddr(r_raddr), .re(r_re), .dataout(r_dout),
    .waddr(r_waddr), .datain(r_din), .be(r_be), .we(r_we), .clear(r_clear),
    .busy(r_busy)
  );

  dpram_param #(.ADDRW(5), .DATAW(8), .READ_REG(0)) u_async (
    .clk(clk), .reset(reset), .raddr(a_raddr), .re(a_re), .dataout(a_dout),
    .waddr(a_waddr), .datain(a_din), .be(a_be), .we(a_we), .clear(a_clear),
    .busy(a_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) begin
      model_r[i] = 32'h0;
      model_a[i] = 8'h0;
    end
  endtask

  // Counts cycles with busy high on the registered instance, bounded.
  task automatic measure_busy(output int cycles);
    cycles = (r_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 200 && r_busy === 1'b1; i++) begin
      tick();
      if (r_busy === 1'b1) cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles;
    reset = 1'b1;
    #1;
    n_checks++;
    if (r_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_r got %b want 1", r_busy); end
    n_checks++;
    if (r_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout_r got %h want 0", r_dout); end
    n_checks++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a got %b want 1", a_busy); end
    tick();
    tick();
    reset = 1'b0;
    measure_busy(cycles);
    n_checks++;
    if (cycles != 32) begin n_fail++; $display("FAIL reset_busy_len got %0d want 32", cycles); end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a_end got %b want 0", a_busy); end
    zero_models();
    for (int a = 0; a < 32; a++) begin
      r_re = 1'b1;
      r_raddr = 5'(a);
      a_raddr = 5'(a);
      tick();
      n_checks++;
      if (r_dout !== model_r[a]) begin n_fail++; $display("FAIL reset_read_r[%0d] got %h want %h", a, r_dout, model_r[a]); end
      n_checks++;
      if (a_dout !== model_a[a]) begin n_fail++; $display("FAIL reset_read_a[%0d] got %h want %h", a, a_dout, model_a[a]); end
    end
    r_re = 1'b0;
    exp_rd = 32'h0;
  endtask

  task automatic test_byte_enable();
    r_we = 1'b1; r_waddr = 5'd3; r_din = 32'hA1B2C3D4; r_be = 4'b1111;
    tick();
    r_din = 32'h00000055; r_be = 4'b0001;
    tick();
    r_din = 32'h0; r_be = 4'b0000;
    tick();
    r_we = 1'b0;
    model_r[3] = 32'hA1B2C355;
    r_re = 1'b1; r_raddr = 5'd3;
    tick();
    r_re = 1'b0;
    exp_rd = model_r[3];
    n_checks++;
    if (r_dout !== 32'hA1B2C355) begin n_fail++; $display("FAIL byte_enable got %h want a1b2c355", r_dout); end
  endtask

  task automatic test_write_first();
    r_we = 1'b1; r_waddr = 5'd7; r_din = 32'h11223344; r_be = 4'hF;
    tick();
    r_din = 32'hFFFFFFFF; r_be = 4'b1100;
    r_re = 1'b1; r_raddr = 5'd7;
    tick();
    r_we = 1'b0;
    model_r[7] = 32'hFFFF3344;
    n_checks++;
    if (r_dout !== 32'hFFFF3344) begin n_fail++; $display("FAIL write_first got %h want ffff3344", r_dout); end
    tick();
    n_checks++;
    if (r_dout !== model_r[7]) begin n_fail++; $display("FAIL write_first_mem got %h want %h", r_dout, model_r[7]); end
    r_re = 1'b0;
    exp_rd = model_r[7];
    // With re low the registered output must hold across a changed address.
    r_raddr = 5'd3;
    tick();
    n_checks++;
    if (r_dout !== exp_rd) begin n_fail++; $display("FAIL read_hold got %h want %h", r_dout, exp_rd); end
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    int ra;
    for (int c = 0; c < 300; c++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_be    = 4'($urandom);
      r_waddr = 5'($urandom_range(0, 7));
      r_din   = $urandom;
      r_re    = 1'($urandom_range(0, 1));
      r_raddr = 5'($urandom_range(0, 7));
      a_we    = 1'($urandom_range(0, 1));
      a_be    = 1'($urandom);
      a_waddr = 5'($urandom_range(0, 31));
      a_din   = 8'($urandom);
      if (r_re) begin
        nxt = model_r[r_raddr];
        for (int b = 0; b < 4; b++)
          if (r_we && r_be[b] && r_raddr == r_waddr) nxt[8*b +: 8] = r_din[8*b +: 8];
        exp_rd = nxt;
      end
      if (r_we)
        for (int b = 0; b < 4; b++)
          if (r_be[b]) model_r[r_waddr][8*b +: 8] = r_din[8*b +: 8];
      if (a_we && a_be[0]) model_a[a_waddr] = a_din;
      tick();
      n_checks++;
      if (r_dout !== exp_rd) begin n_fail++; $display("FAIL random_r cycle %0d got %h want %h", c, r_dout, exp_rd); end
      ra = $urandom_range(0, 31);
      a_raddr = 5'(ra);
      a_we = 1'b0;
      #1;
      n_checks++;
      if (a_dout !== model_a[ra]) begin n_fail++; $display("FAIL random_a cycle %0d addr %0d got %h want %h", c, ra, a_dout, model_a[ra]); end
    end
    r_we = 1'b0; r_re = 1'b0; a_we = 1'b0;
  endtask

  task automatic test_clear_restart();
    int cycles;
    r_we = 1'b1; r_be = 4'hF;
    r_waddr = 5'd5;  r_din = 32'h0BADF00D; tick();
    r_waddr = 5'd10; r_din = 32'h13572468; tick();
    r_we = 1'b0;
    r_re = 1'b1; r_raddr = 5'd5;
    tick();
    r_re = 1'b0;
    n_checks++;
    if (r_dout !== 32'h0BADF00D) begin n_fail++; $display("FAIL clear_pre_read got %h want 0badf00d", r_dout); end
    r_clear = 1'b1;
    tick();
    r_clear = 1'b0;
    n_checks++;
    if (r_busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy got %b want 1", r_busy); end
    n_checks++;
    if (r_dout !== 32'h0) begin n_fail++; $display("FAIL clear_dout_zero got %h want 0", r_dout); end
    repeat (10) tick();
    r_clear = 1'b1;
    tick();
    r_clear = 1'b0;
    cycles = (r_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 200 && r_busy === 1'b1; i++) begin
      if (i == 20) begin
        r_we = 1'b1; r_waddr = 5'd3; r_din = 32'hCAFEF00D; r_be = 4'hF;
        r_re = 1'b1; r_raddr = 5'd5;
        n_checks++;
        if (r_dout !== 32'h0) begin n_fail++; $display("FAIL clear_busy_read got %h want 0", r_dout); end
      end else begin
        r_we = 1'b0;
        r_re = 1'b0;
      end
      tick();
      if (r_busy === 1'b1) cycles++;
    end
    r_we = 1'b0; r_re = 1'b0;
    n_checks++;
    if (cycles != 32) begin n_fail++; $display("FAIL clear_restart_len got %0d want 32", cycles); end
    for (int i = 0; i < 32; i++) model_r[i] = 32'h0;
    n_checks++;
    if (r_dout !== 32'h0) begin n_fail++; $display("FAIL clear_after_dout got %h want 0", r_dout); end
    for (int k = 0; k < 3; k++) begin
      r_re = 1'b1;
      r_raddr = (k == 0) ? 5'd3 : (k == 1) ? 5'd5 : 5'd10;
      tick();
      n_checks++;
      if (r_dout !== model_r[r_raddr]) begin n_fail++; $display("FAIL clear_after_read[%0d] got %h want %h", r_raddr, r_dout, model_r[r_raddr]); end
    end
    r_re = 1'b0;
    exp_rd = 32'h0;
  endtask

  task automatic test_reset_during_read();
    int cycles;
    r_we = 1'b1; r_waddr = 5'd9; r_din = 32'hDEADBEEF; r_be = 4'hF;
    tick();
    r_we = 1'b0;
    r_re = 1'b1; r_raddr = 5'd9;
    tick();
    r_re = 1'b0;
    n_checks++;
    if (r_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_pre_read got %h want deadbeef", r_dout); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (r_dout !== 32'h0) begin n_fail++; $display("FAIL rst_async_dout got %h want 0", r_dout); end
    n_checks++;
    if (r_busy !== 1'b1) begin n_fail++; $display("FAIL rst_async_busy got %b want 1", r_busy); end
    tick();
    reset = 1'b0;
    measure_busy(cycles);
    n_checks++;
    if (cycles != 32) begin n_fail++; $display("FAIL rst_rerun_len got %0d want 32", cycles); end
    zero_models();
    exp_rd = 32'h0;
    r_re = 1'b1; r_raddr = 5'd9;
    tick();
    r_re = 1'b0;
    n_checks++;
    if (r_dout !== model_r[9]) begin n_fail++; $display("FAIL rst_after_read got %h want %h", r_dout, model_r[9]); end
  endtask

  task automatic test_async_read();
    a_we = 1'b1; a_be = 1'b1; a_waddr = 5'd31; a_din = 8'h5A; a_raddr = 5'd31;
    #1;
    n_checks++;
    if (a_dout !== model_a[31]) begin n_fail++; $display("FAIL async_pre_edge got %h want %h", a_dout, model_a[31]); end
    tick();
    a_we = 1'b0;
    model_a[31] = 8'h5A;
    n_checks++;
    if (a_dout !== 8'h5A) begin n_fail++; $display("FAIL async_after_edge got %h want 5a", a_dout); end
    a_raddr = 5'd0;
    #1;
    n_checks++;
    if (a_dout !== model_a[0]) begin n_fail++; $display("FAIL async_addr0 got %h want %h", a_dout, model_a[0]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_rd = 32'h0;
    reset = 1'b1;
    r_raddr = '0; r_waddr = '0; r_re = 1'b0; r_we = 1'b0; r_clear = 1'b0;
    r_din = '0; r_be = '0;
    a_raddr = '0; a_waddr = '0; a_re = 1'b0; a_we = 1'b0; a_clear = 1'b0;
    a_din = '0; a_be = '0;
    zero_models();

    test_reset();
    test_byte_enable();
    test_write_first();
    test_random();
    test_clear_restart();
    test_reset_during_read();
    test_async_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
